// File: rtl/prbs_err_monitor.sv
// PRBS lock FSM plus saturating error statistics; outputs registered, stats reflect a word 1 cycle later.
// No backpressure: every err_in_valid word is consumed in the cycle it is presented.
module prbs_err_monitor #(
    parameter int DATA_WIDTH    = 8,
    parameter int COUNT_WIDTH   = 32,
    parameter int LOCK_COUNT    = 64,
    parameter int UNLOCK_ERRORS = 16,
    parameter int WINDOW        = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  err_in,
    input  logic                   err_in_valid,
    input  logic                   clear,
    output logic                   locked,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic [COUNT_WIDTH-1:0] bit_err_count,
    output logic [COUNT_WIDTH-1:0] err_word_count,
    output logic [COUNT_WIDTH-1:0] lock_loss_count
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam int ERR_W = $clog2(UNLOCK_ERRORS + 1);
    localparam int PC_W  = $clog2(DATA_WIDTH + 1);
    localparam int SUM_W = ((COUNT_WIDTH > PC_W) ? COUNT_WIDTH : PC_W) + 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state;
    logic [RUN_W-1:0] run_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [ERR_W-1:0] win_err_cnt;

    logic [PC_W-1:0]        err_pop;
    logic                   err_any;
    logic [SUM_W-1:0]       bit_sum;
    logic [COUNT_WIDTH-1:0] bit_next;
    logic [ERR_W-1:0]       win_err_inc;
    logic                   unlock_hit;
    logic                   win_last;
    logic                   run_hit;

    function automatic logic [PC_W-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + COUNT_WIDTH'(1);
    endfunction

    always_comb begin
        err_pop     = popcount(err_in);
        err_any     = |err_in;
        // Sum one bit wider than either operand so the clamp sees the true overflow.
        bit_sum     = SUM_W'(bit_err_count) + SUM_W'(err_pop);
        bit_next    = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bit_sum[COUNT_WIDTH-1:0];
        win_err_inc = win_err_cnt + ERR_W'(1);
        unlock_hit  = err_any && (win_err_inc == ERR_W'(UNLOCK_ERRORS));
        win_last    = (win_cnt == WIN_W'(WINDOW - 1));
        run_hit     = (run_cnt == RUN_W'(LOCK_COUNT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= UNLOCKED;
            locked          <= 1'b0;
            run_cnt         <= '0;
            win_cnt         <= '0;
            win_err_cnt     <= '0;
            word_count      <= '0;
            bit_err_count   <= '0;
            err_word_count  <= '0;
            lock_loss_count <= '0;
        end else begin
            if (err_in_valid) begin
                case (state)
                    UNLOCKED: begin
                        if (err_any) begin
                            run_cnt <= '0;
                        end else if (run_hit) begin
                            // The locking word itself never reaches the statistics.
                            state       <= LOCKED;
                            locked      <= 1'b1;
                            run_cnt     <= '0;
                            win_cnt     <= '0;
                            win_err_cnt <= '0;
                        end else begin
                            run_cnt <= run_cnt + RUN_W'(1);
                        end
                    end
                    LOCKED: begin
                        word_count    <= sat_inc(word_count);
                        bit_err_count <= bit_next;
                        if (err_any) begin
                            err_word_count <= sat_inc(err_word_count);
                        end
                        // Unlock beats the window wrap when both land on the same word.
                        if (unlock_hit) begin
                            state           <= UNLOCKED;
                            locked          <= 1'b0;
                            lock_loss_count <= sat_inc(lock_loss_count);
                            run_cnt         <= '0;
                            win_cnt         <= '0;
                            win_err_cnt     <= '0;
                        end else if (win_last) begin
                            win_cnt     <= '0;
                            win_err_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            if (err_any) begin
                                win_err_cnt <= win_err_inc;
                            end
                        end
                    end
                endcase
            end
            // Later assignment: clear overrides any statistics update above.
            if (clear) begin
                word_count      <= '0;
                bit_err_count   <= '0;
                err_word_count  <= '0;
                lock_loss_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs_err_monitor.sv
// Bench for prbs_err_monitor: vector table, directed corner sequences, and random traffic against a reference model.
module tb_prbs_err_monitor;

    localparam int DW  = 8;
    localparam int CWA = 16;
    localparam int CWB = 4;
    localparam int LC  = 4;
    localparam int UE  = 2;
    localparam int WIN = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [DW-1:0]  err_in = '0;
    logic           err_in_valid = 1'b0;
    logic           clear = 1'b0;

    logic           locked_a, locked_b;
    logic [CWA-1:0] words_a, bits_a, errw_a, loss_a;
    logic [CWB-1:0] words_b, bits_b, errw_b, loss_b;

    prbs_err_monitor #(.DATA_WIDTH(DW), .COUNT_WIDTH(CWA), .LOCK_COUNT(LC),
                       .UNLOCK_ERRORS(UE), .WINDOW(WIN)) dut_a (
        .clk(clk), .rst(rst), .err_in(err_in), .err_in_valid(err_in_valid), .clear(clear),
        .locked(locked_a), .word_count(words_a), .bit_err_count(bits_a),
        .err_word_count(errw_a), .lock_loss_count(loss_a));

    prbs_err_monitor #(.DATA_WIDTH(DW), .COUNT_WIDTH(CWB), .LOCK_COUNT(LC),
                       .UNLOCK_ERRORS(UE), .WINDOW(WIN)) dut_b (
        .clk(clk), .rst(rst), .err_in(err_in), .err_in_valid(err_in_valid), .clear(clear),
        .locked(locked_b), .word_count(words_b), .bit_err_count(bits_b),
        .err_word_count(errw_b), .lock_loss_count(loss_b));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain integer bookkeeping of the lock rules.
    bit     m_locked;
    int     m_run, m_win, m_werr;
    longint m_words, m_bits, m_errw, m_loss;

    task automatic model_step(input bit r, input bit c, input bit v, input logic [DW-1:0] e);
        if (r) begin
            m_locked = 0; m_run = 0; m_win = 0; m_werr = 0;
            m_words = 0; m_bits = 0; m_errw = 0; m_loss = 0;
            return;
        end
        if (v) begin
            if (!m_locked) begin
                if (e == 0) begin
                    m_run++;
                    if (m_run == LC) begin
                        m_locked = 1; m_run = 0; m_win = 0; m_werr = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                m_words++;
                m_bits += $countones(e);
                if (e != 0) begin
                    m_errw++;
                    m_werr++;
                end
                if (m_werr == UE) begin
                    m_locked = 0; m_loss++; m_run = 0; m_win = 0; m_werr = 0;
                end else begin
                    m_win++;
                    if (m_win == WIN) begin
                        m_win = 0; m_werr = 0;
                    end
                end
            end
        end
        if (c) begin
            m_words = 0; m_bits = 0; m_errw = 0; m_loss = 0;
        end
    endtask

    function automatic longint sat(input longint x, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at vector %0d: got %0d, expected %0d", name, n_vec, act, exp);
        end
    endtask

    // Present one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic drive(input bit r, input bit c, input bit v, input logic [DW-1:0] e);
        @(negedge clk);
        rst = r; clear = c; err_in_valid = v; err_in = e;
        model_step(r, c, v, e);
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    task automatic check_a(input string tag, input bit l, input longint w, input longint b,
                           input longint ew, input longint ll);
        chk({tag, ".locked"}, longint'(locked_a), longint'(l));
        chk({tag, ".word_count"}, longint'(words_a), w);
        chk({tag, ".bit_err_count"}, longint'(bits_a), b);
        chk({tag, ".err_word_count"}, longint'(errw_a), ew);
        chk({tag, ".lock_loss_count"}, longint'(loss_a), ll);
    endtask

    task automatic check_model(input string tag);
        check_a(tag, m_locked, sat(m_words, CWA), sat(m_bits, CWA), sat(m_errw, CWA), sat(m_loss, CWA));
        chk({tag, ".b.locked"}, longint'(locked_b), longint'(m_locked));
        chk({tag, ".b.word_count"}, longint'(words_b), sat(m_words, CWB));
        chk({tag, ".b.bit_err_count"}, longint'(bits_b), sat(m_bits, CWB));
        chk({tag, ".b.err_word_count"}, longint'(errw_b), sat(m_errw, CWB));
        chk({tag, ".b.lock_loss_count"}, longint'(loss_b), sat(m_loss, CWB));
    endtask

    typedef struct {
        bit          rst;
        bit          clr;
        bit          vld;
        logic [7:0]  err;
        bit          locked;
        int          words;
        int          bits;
        int          errw;
        int          loss;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // rst clr vld err | locked words bits errw loss
        tbl.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 8'h00, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 8'hFF, 1, 1, 8, 1, 0});
        tbl.push_back('{0, 0, 1, 8'h00, 1, 2, 8, 1, 0});
        tbl.push_back('{0, 0, 1, 8'h03, 0, 3, 10, 2, 1});
        tbl.push_back('{0, 0, 0, 8'hFF, 0, 3, 10, 2, 1});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 3, 10, 2, 1});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 3, 10, 2, 1});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 3, 10, 2, 1});
        tbl.push_back('{0, 0, 1, 8'h01, 0, 3, 10, 2, 1});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 3, 10, 2, 1});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 3, 10, 2, 1});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 3, 10, 2, 1});
        tbl.push_back('{0, 0, 1, 8'h00, 1, 3, 10, 2, 1});
        tbl.push_back('{0, 1, 1, 8'h01, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 8'h00, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 8'h01, 0, 2, 1, 1, 1});
        tbl.push_back('{1, 1, 1, 8'hFF, 0, 0, 0, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].clr, tbl[i].vld, tbl[i].err);
            check_a($sformatf("tbl[%0d]", i), tbl[i].locked, tbl[i].words, tbl[i].bits,
                    tbl[i].errw, tbl[i].loss);
        end

        // One 0xFF per window for two windows: stays locked; the 4-bit instance saturates.
        drive(1, 0, 0, 8'h00);
        for (int i = 0; i < LC; i++) drive(0, 0, 1, 8'h00);
        for (int i = 0; i < 2 * WIN; i++) drive(0, 0, 1, (i % WIN == 0) ? 8'hFF : 8'h00);
        check_a("win16", 1, 16, 16, 2, 0);
        chk("win16.b.word_count", longint'(words_b), 15);
        chk("win16.b.bit_err_count", longint'(bits_b), 15);
        chk("win16.b.err_word_count", longint'(errw_b), 2);

        // Errors on the last and first word of adjacent windows do not unlock.
        for (int i = 0; i < WIN - 1; i++) drive(0, 0, 1, 8'h00);
        drive(0, 0, 1, 8'h01);
        drive(0, 0, 1, 8'h01);
        check_a("wrap_edge", 1, 25, 18, 4, 0);
        // Second error lands on the last word of a window: unlock wins over wrap.
        for (int i = 0; i < WIN - 2; i++) drive(0, 0, 1, 8'h00);
        check_a("pre_unlock", 1, 31, 18, 4, 0);
        drive(0, 0, 1, 8'h01);
        check_a("unlock_at_wrap", 0, 32, 19, 5, 1);

        // Reset mid-run discards progress: a full run is needed again.
        for (int i = 0; i < LC - 1; i++) drive(0, 0, 1, 8'h00);
        drive(1, 0, 1, 8'h00);
        check_a("rst_mid_run", 0, 0, 0, 0, 0);
        for (int i = 0; i < LC - 1; i++) drive(0, 0, 1, 8'h00);
        chk("relock_early.locked", longint'(locked_a), 0);
        drive(0, 0, 1, 8'h00);
        chk("relock.locked", longint'(locked_a), 1);

        // Random traffic against the model.
        drive(1, 0, 0, 8'h00);
        check_model("rnd_reset");
        for (int i = 0; i < 3000; i++) begin
            bit          r, c, v;
            logic [7:0]  e;
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 79) == 0);
            v = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 9))
                0, 1:    e = 8'($urandom_range(0, 255));
                2:       e = 8'(1 << $urandom_range(0, 7));
                default: e = 8'h00;
            endcase
            drive(r, c, v, e);
            check_model("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs_err_monitor.md
PRBS_ERR_MONITOR -- requirements
Module: prbs_err_monitor

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of error vector input.
REQ-002 Parameter COUNT_WIDTH, default 32: width of each statistics counter.
REQ-003 Parameter LOCK_COUNT, default 64: consecutive error-free words needed to declare lock; valid range 1..2^16.
REQ-004 Parameter UNLOCK_ERRORS, default 16: errored words within one window that force loss of lock; valid range 1..WINDOW.
REQ-005 Parameter WINDOW, default 256: window length in valid words for unlock evaluation; valid range 1..2^16.
REQ-006 Port clk  input  1  clock; all logic on rising edge.
REQ-007 Port rst  input  1  reset, synchronous, active-high.
REQ-008 Port err_in  input  DATA_WIDTH  per-bit error vector from PRBS checker; 1 = bit error.
REQ-009 Port err_in_valid  input  1  err_in carries a new word this cycle; the integrator aligns it to the checker's registered output.
REQ-010 Port clear  input  1  synchronous clear of statistics counters; lock state unaffected.
REQ-011 Port locked  output  1  high while in LOCKED state.
REQ-012 Port word_count  output  COUNT_WIDTH  valid words counted while locked.
REQ-013 Port bit_err_count  output  COUNT_WIDTH  total error bits counted while locked.
REQ-014 Port err_word_count  output  COUNT_WIDTH  words with at least one error bit counted while locked.
REQ-015 Port lock_loss_count  output  COUNT_WIDTH  LOCKED->UNLOCKED transitions since reset/clear.

Function
REQ-016 Cycles with err_in_valid low SHALL change no state or output.
REQ-017 FSM SHALL have two states, UNLOCKED and LOCKED; locked SHALL equal (state == LOCKED), registered.
REQ-018 UNLOCKED: valid word with err_in == 0 SHALL increment run counter; nonzero word SHALL zero it.
REQ-019 UNLOCKED: when the valid error-free word brings run counter to LOCK_COUNT, SHALL enter LOCKED next cycle, zero run, window and window-error counters.
REQ-020 The word causing lock SHALL NOT be counted in any statistics counter.
REQ-021 LOCKED: each valid word SHALL increment word_count, add popcount(err_in) to bit_err_count, increment err_word_count if err_in != 0.
REQ-022 LOCKED: window counter SHALL count valid words 0..WINDOW-1; window-error counter SHALL count errored words in current window.
REQ-023 LOCKED: when an errored word brings window-error counter to UNLOCK_ERRORS, SHALL enter UNLOCKED next cycle, increment lock_loss_count, zero run/window counters; that word IS counted in statistics.
REQ-024 LOCKED: on the WINDOW-th valid word without unlock, window and window-error counters SHALL both return to 0 (that word's error, if any, evaluated before wrap).
REQ-025 Unlock (REQ-023) SHALL take priority over window wrap on the same word.
REQ-026 All statistics counters SHALL saturate at 2^COUNT_WIDTH-1 and never wrap; bit_err_count addition SHALL clamp.
REQ-027 Statistics outputs SHALL reflect a valid word one cycle after it is presented (latency 1).
REQ-028 clear high SHALL zero all four statistics counters next cycle; clear with simultaneous valid word: clear wins for statistics, FSM still processes the word.
REQ-029 Popcount SHALL be computed over all DATA_WIDTH bits without truncation.

Reset
REQ-030 rst SHALL force UNLOCKED, locked=0, all counters (run, window, window-error, statistics) to 0 next cycle; rst overrides clear and err_in_valid.
REQ-031 rst mid-window or mid-run SHALL discard partial progress; relock requires a full LOCK_COUNT run.

Verification (DATA_WIDTH=8, LOCK_COUNT=4, UNLOCK_ERRORS=2, WINDOW=8)
REQ-032 4 valid zero words after reset -> locked=1 cycle after 4th word; word_count=0.
REQ-033 3 zero words, 1 word 0x01, 4 zero words -> locked rises only after 8th word.
REQ-034 Locked, words 0xFF,0x00,0x03 -> bit_err_count=10, err_word_count=2, word_count=3, locked=0 after 3rd, lock_loss_count=1.
REQ-035 Locked, error word at window positions 0 and 8 (one per window), 16 words -> stays locked, err_word_count=2.
REQ-036 COUNT_WIDTH=4, locked, 2 words 0xFF in separate windows -> bit_err_count saturates at 15.
REQ-037 clear and valid 0x01 same cycle while locked -> all statistics 0, window-error=1, locked=1; rst mid-run -> locked=0, counters 0.
